// File: rtl/ldpc_dec_sched_pkg.sv
// Shared types and helpers for the LDPC engine frame scheduler.
package ldpc_dec_sched_pkg;

  localparam int cMAX_ENGINE = 8;
  localparam int cMAX_ENG_W  = $clog2(cMAX_ENGINE);

  // Sized for the largest engine count; modules cast to their own index width.
  typedef logic [cMAX_ENG_W-1:0] eng_idx_t;

  typedef enum logic [1:0] {cI_IDLE, cI_PICK, cI_XFER} istate_t;
  typedef enum logic [1:0] {cO_IDLE, cO_WAIT, cO_READ, cO_REL} ostate_t;

  function automatic logic [cMAX_ENGINE-1:0] onehot(input eng_idx_t idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/ldpc_dec_sched_fifo.sv
// Order FIFO holding engine indices in dispatch order; count register gives full/empty.
module ldpc_dec_sched_fifo #(
  parameter int pDEPTH = 4,
  parameter int pW     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [pW-1:0] wdata,
  input  logic          pop,
  output logic [pW-1:0] top,
  output logic [pW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [pW-1:0] mem [pDEPTH];
  logic [pW-1:0] wr_ptr;
  logic [pW-1:0] rd_ptr;

  function automatic logic [pW-1:0] ptr_inc(input logic [pW-1:0] p);
    ptr_inc = (p == pW'(pDEPTH - 1)) ? '0 : p + pW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + (pW+1)'(1);
        2'b01:   count <= count - (pW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign top   = mem[rd_ptr];
  assign full  = (count == (pW+1)'(pDEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ldpc_dec_engine_sched.sv
// Frame scheduler: dispatches upstream frames to free LDPC engines round-robin
// and hands decoded frames to a single reader strictly in dispatch order.
module ldpc_dec_engine_sched
  import ldpc_dec_sched_pkg::*;
#(
  parameter int pENGINE_NUM = 4,
  parameter int pENG_W      = $clog2(pENGINE_NUM)
) (
  input  logic                   iclk,
  input  logic                   ireset_n,
  input  logic                   iclkena,
  input  logic                   isop,
  input  logic                   ival,
  input  logic                   ieop,
  output logic                   ordy,
  input  logic [pENGINE_NUM-1:0] iengine_ibuf_full,
  output logic [pENGINE_NUM-1:0] oengine_wsel,
  input  logic [pENGINE_NUM-1:0] iengine_obuf_full,
  output logic [pENGINE_NUM-1:0] oengine_orelease,
  output logic [pENGINE_NUM-1:0] ordsel,
  output logic [pENG_W-1:0]      ordsel_idx,
  output logic                   ord_val,
  input  logic                   iread_done,
  output logic [pENG_W:0]        oinflight
);

  // state   | meaning
  // cI_IDLE | wait for room in the order FIFO
  // cI_PICK | search for a free engine from rr_ptr
  // cI_XFER | stream words to the chosen engine until eop
  // cO_IDLE | order FIFO empty
  // cO_WAIT | wait for the head engine's output buffer
  // cO_READ | reader owns the head engine's output buffer
  // cO_REL  | release the head buffer and pop it

  istate_t istate, istate_nxt;
  ostate_t ostate, ostate_nxt;

  logic [pENG_W-1:0]      rr_ptr;
  logic [pENGINE_NUM-1:0] busy;
  logic [pENG_W:0]        search;
  logic                   found;
  logic [pENG_W-1:0]      pick_idx;
  logic [pENGINE_NUM-1:0] pick_oh;
  logic [pENGINE_NUM-1:0] top_oh;
  logic                   push, pop;
  logic [pENG_W-1:0]      fifo_top;
  logic [pENG_W:0]        fifo_count;
  logic                   fifo_full, fifo_empty;

  // Frames are delimited by eop alone; start-of-frame carries no information here.
  logic sop_unused;
  assign sop_unused = isop;

  function automatic logic [pENG_W:0] rr_search(input logic [pENG_W-1:0]      ptr,
                                                input logic [pENGINE_NUM-1:0] avail);
    logic [pENG_W-1:0] idx;
    rr_search = '0;
    // Walk backwards so the last hit is the nearest engine at or after ptr.
    for (int i = pENGINE_NUM - 1; i >= 0; i--) begin
      idx = pENG_W'((int'(ptr) + i) % pENGINE_NUM);
      if (avail[idx]) rr_search = {1'b1, idx};
    end
  endfunction

  assign search   = rr_search(rr_ptr, ~(iengine_ibuf_full | busy));
  assign found    = search[pENG_W];
  assign pick_idx = search[pENG_W-1:0];
  assign pick_oh  = pENGINE_NUM'(onehot(eng_idx_t'(pick_idx)));
  assign top_oh   = pENGINE_NUM'(onehot(eng_idx_t'(fifo_top)));

  ldpc_dec_sched_fifo #(.pDEPTH(pENGINE_NUM), .pW(pENG_W)) u_fifo (
    .clk   (iclk),
    .rst_n (ireset_n),
    .push  (push),
    .wdata (pick_idx),
    .pop   (pop),
    .top   (fifo_top),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign oinflight = fifo_count;

  always_comb begin
    istate_nxt = istate;
    push       = 1'b0;
    case (istate)
      cI_IDLE: if (!fifo_full) istate_nxt = cI_PICK;
      cI_PICK: if (found) begin
        istate_nxt = cI_XFER;
        push       = iclkena;
      end
      cI_XFER: if (ival && ieop) istate_nxt = cI_IDLE;
      default: istate_nxt = cI_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      istate       <= cI_IDLE;
      rr_ptr       <= '0;
      busy         <= '0;
      ordy         <= 1'b0;
      oengine_wsel <= '0;
    end else if (iclkena) begin
      istate <= istate_nxt;
      // Pop clears the head's bit; the head is busy so it can never equal pick_idx.
      busy   <= (busy & ~(pop ? top_oh : '0)) | (push ? pick_oh : '0);
      if (push) begin
        rr_ptr       <= (pick_idx == pENG_W'(pENGINE_NUM - 1)) ? '0 : pick_idx + pENG_W'(1);
        ordy         <= 1'b1;
        oengine_wsel <= pick_oh;
      end else if (istate == cI_XFER && ival && ieop) begin
        ordy         <= 1'b0;
        oengine_wsel <= '0;
      end
    end
  end

  always_comb begin
    ostate_nxt = ostate;
    pop        = 1'b0;
    case (ostate)
      cO_IDLE: if (!fifo_empty) ostate_nxt = cO_WAIT;
      cO_WAIT: if (iengine_obuf_full[fifo_top]) ostate_nxt = cO_READ;
      cO_READ: if (iread_done) ostate_nxt = cO_REL;
      cO_REL: begin
        pop        = iclkena;
        ostate_nxt = (fifo_count > (pENG_W+1)'(1) || push) ? cO_WAIT : cO_IDLE;
      end
      default: ostate_nxt = cO_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      ostate           <= cO_IDLE;
      ord_val          <= 1'b0;
      ordsel           <= '0;
      ordsel_idx       <= '0;
      oengine_orelease <= '0;
    end else if (iclkena) begin
      ostate           <= ostate_nxt;
      oengine_orelease <= '0;
      if (ostate == cO_WAIT && ostate_nxt == cO_READ) begin
        ord_val    <= 1'b1;
        ordsel     <= top_oh;
        ordsel_idx <= fifo_top;
      end else if (ostate == cO_READ && ostate_nxt == cO_REL) begin
        ord_val          <= 1'b0;
        ordsel           <= '0;
        ordsel_idx       <= '0;
        oengine_orelease <= top_oh;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_dec_engine_sched.sv
// Directed bench for the LDPC engine scheduler: dispatch table plus ordering,
// push/pop, clock-enable and async-reset sequences.
module tb_ldpc_dec_engine_sched;

  logic       iclk = 1'b0;
  logic       ireset_n, iclkena, isop, ival, ieop, iread_done;
  logic       ordy, ord_val;
  logic [3:0] iengine_ibuf_full, iengine_obuf_full;
  logic [3:0] oengine_wsel, oengine_orelease, ordsel;
  logic [1:0] ordsel_idx;
  logic [2:0] oinflight;

  int n_cmp = 0;
  int n_err = 0;
  int acc_words = 0;

  typedef struct {
    bit         do_reset;
    logic [3:0] ibuf;
    int         nwords;
    logic [3:0] exp_wsel;
    int         exp_inflight;
  } disp_vec_t;

  disp_vec_t tab [7];

  ldpc_dec_engine_sched #(.pENGINE_NUM(4)) dut (
    .iclk              (iclk),
    .ireset_n          (ireset_n),
    .iclkena           (iclkena),
    .isop              (isop),
    .ival              (ival),
    .ieop              (ieop),
    .ordy              (ordy),
    .iengine_ibuf_full (iengine_ibuf_full),
    .oengine_wsel      (oengine_wsel),
    .iengine_obuf_full (iengine_obuf_full),
    .oengine_orelease  (oengine_orelease),
    .ordsel            (ordsel),
    .ordsel_idx        (ordsel_idx),
    .ord_val           (ord_val),
    .iread_done        (iread_done),
    .oinflight         (oinflight)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk)
    if (ireset_n && iclkena && ival && ordy) acc_words = acc_words + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    ireset_n = 1'b0;
    iclkena = 1'b1; isop = 1'b0; ival = 1'b0; ieop = 1'b0; iread_done = 1'b0;
    iengine_ibuf_full = '0; iengine_obuf_full = '0;
    repeat (2) tick();
    check("rst_ordy", ordy, 0);
    check("rst_wsel", oengine_wsel, 0);
    check("rst_ord_val", ord_val, 0);
    check("rst_inflight", oinflight, 0);
    ireset_n = 1'b1;
  endtask

  task automatic wait_ordy();
    for (int i = 0; i < 20; i++) begin
      if (ordy) break;
      tick();
    end
    check("ordy_wait", ordy, 1);
  endtask

  task automatic send_frame(input int n);
    for (int w = 0; w < n; w++) begin
      isop = (w == 0); ival = 1'b1; ieop = (w == n - 1);
      tick();
    end
    isop = 1'b0; ival = 1'b0; ieop = 1'b0;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      if (tab[k].do_reset) do_reset();
      iengine_ibuf_full = tab[k].ibuf;
      wait_ordy();
      check($sformatf("disp%0d_wsel", k), oengine_wsel, tab[k].exp_wsel);
      send_frame(tab[k].nwords);
      check($sformatf("disp%0d_inflight", k), oinflight, tab[k].exp_inflight);
    end
  endtask

  initial begin
    int seen;
    int start;
    tab[0] = '{1'b1, 4'b0000, 16, 4'b0001, 1};
    tab[1] = '{1'b0, 4'b0000, 16, 4'b0010, 2};
    tab[2] = '{1'b0, 4'b0000, 16, 4'b0100, 3};
    tab[3] = '{1'b0, 4'b0000, 16, 4'b1000, 4};
    tab[4] = '{1'b1, 4'b0000,  4, 4'b0001, 1};
    tab[5] = '{1'b0, 4'b0010,  4, 4'b0100, 2};
    tab[6] = '{1'b0, 4'b0000,  4, 4'b1000, 3};

    // Basic dispatch, fifth frame blocked, out-of-order completion.
    run_table(0, 3);
    seen = 0;
    repeat (8) begin tick(); seen |= int'(ordy); end
    check("full_blocks_ordy", seen, 0);
    iengine_obuf_full = 4'b0010;
    repeat (3) tick();
    check("ooo_hold_ord_val", ord_val, 0);
    iengine_obuf_full = 4'b0011;
    tick();
    check("ooo_first_val", ord_val, 1);
    check("ooo_first_sel", ordsel, 4'b0001);
    check("ooo_first_idx", ordsel_idx, 0);
    iread_done = 1'b1;
    tick();
    iread_done = 1'b0;
    iengine_obuf_full = 4'b0010;
    check("ooo_release0", oengine_orelease, 4'b0001);
    check("ooo_rel_val", ord_val, 0);
    tick();
    check("ooo_release_pulse", oengine_orelease, 0);
    wait_ordy();
    check("fifth_wsel", oengine_wsel, 4'b0001);
    check("ooo_second_sel", ordsel, 4'b0010);
    check("ooo_second_idx", ordsel_idx, 1);
    send_frame(16);
    check("fifth_inflight", oinflight, 4);

    // Skip engine with full input buffer, then simultaneous push/pop.
    run_table(4, 6);
    iengine_ibuf_full = 4'b1111;
    iengine_obuf_full = 4'b0001;
    tick();
    check("pp_sel0", ordsel, 4'b0001);
    iread_done = 1'b1;
    tick();
    iread_done = 1'b0;
    iengine_obuf_full = 4'b0000;
    tick();
    check("pp_inflight_a", oinflight, 2);
    iengine_obuf_full = 4'b0100;
    tick();
    check("pp_sel2", ordsel, 4'b0100);
    iread_done = 1'b1;
    tick();
    check("pp_release2", oengine_orelease, 4'b0100);
    check("pp_inflight_b", oinflight, 2);
    iread_done = 1'b0;
    iengine_obuf_full = 4'b0000;
    iengine_ibuf_full = 4'b1110;
    tick();
    check("pp_inflight_c", oinflight, 2);
    check("pp_ordy", ordy, 1);
    check("pp_wsel", oengine_wsel, 4'b0001);
    send_frame(4);
    iengine_obuf_full = 4'b1001;
    tick();
    check("pp_order_first", ordsel, 4'b1000);
    iread_done = 1'b1;
    tick();
    iread_done = 1'b0;
    iengine_obuf_full = 4'b0001;
    repeat (2) tick();
    check("pp_order_second", ordsel, 4'b0001);

    // Clock enable held low mid-transfer.
    do_reset();
    wait_ordy();
    check("ce_wsel_start", oengine_wsel, 4'b0001);
    start = acc_words;
    for (int w = 0; w < 6; w++) begin
      isop = (w == 0); ival = 1'b1; ieop = 1'b0;
      tick();
    end
    iclkena = 1'b0; isop = 1'b0; ieop = 1'b1;
    repeat (5) tick();
    check("ce_hold_ordy", ordy, 1);
    check("ce_hold_wsel", oengine_wsel, 4'b0001);
    check("ce_hold_inflight", oinflight, 1);
    iclkena = 1'b1; ieop = 1'b0;
    for (int w = 0; w < 10; w++) begin
      isop = (w == 2); ival = 1'b1; ieop = (w == 9);
      tick();
    end
    isop = 1'b0; ival = 1'b0; ieop = 1'b0;
    check("ce_words", acc_words - start, 16);
    check("ce_eop_ordy", ordy, 0);

    // Asynchronous reset during a read.
    iengine_obuf_full = 4'b0001;
    repeat (3) tick();
    check("ar_pre_val", ord_val, 1);
    check("ar_pre_ordy", ordy, 1);
    #2 ireset_n = 1'b0;
    #1;
    check("ar_val", ord_val, 0);
    check("ar_sel", ordsel, 0);
    check("ar_ordy", ordy, 0);
    check("ar_wsel", oengine_wsel, 0);
    check("ar_inflight", oinflight, 0);
    iengine_obuf_full = 4'b0000;
    repeat (2) tick();
    ireset_n = 1'b1;
    tick();
    check("ar_post_inflight", oinflight, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ldpc_dec_engine_sched.md
Name: ldpc_dec_engine_sched

Overview:
Frame scheduler that shares one upstream LLR stream among pENGINE_NUM parallel LDPC decoder engines. Each engine runs its own main decode FSM with its own input and output buffers. The scheduler dispatches each incoming frame to a free engine in round-robin order and records the engine index in an order FIFO. It then hands engine output buffers to a single downstream reader in strict arrival order and releases each buffer after it is read.

Parameters:
pENGINE_NUM, 4, number of decoder engines (2..8)
pENG_W, $clog2(pENGINE_NUM), engine index width (derived, do not override)

Ports:
iclk  in  1  clock
ireset_n  in  1  asynchronous active-low reset
iclkena  in  1  clock enable; when low, all state holds
isop  in  1  upstream frame start, qualified by ival
ival  in  1  upstream word valid
ieop  in  1  upstream frame end, qualified by ival
ordy  out  1  scheduler can accept an upstream word this cycle
iengine_ibuf_full  in  pENGINE_NUM  per-engine input buffer holds a frame awaiting decode
oengine_wsel  out  pENGINE_NUM  one-hot write select; routes upstream words to the chosen engine
iengine_obuf_full  in  pENGINE_NUM  per-engine output buffer holds a decoded frame
oengine_orelease  out  pENGINE_NUM  one-hot, one-cycle pulse; frees that engine's output buffer
ordsel  out  pENGINE_NUM  one-hot read select for the downstream output mux
ordsel_idx  out  pENG_W  binary form of ordsel
ord_val  out  1  ordsel is valid and the reader may read
iread_done  in  1  reader finished the current frame (single-cycle pulse)
oinflight  out  pENG_W+1  number of frames dispatched but not yet released

Behaviour:
- Reset (ireset_n=0, asynchronous): all outputs 0; rr_ptr=0; order FIFO empty; both FSMs in IDLE.
- All state updates are gated by iclkena.

Input FSM:
- States: cI_IDLE, cI_PICK, cI_XFER.
- cI_IDLE -> cI_PICK when the order FIFO is not full. This is always true when fewer than pENGINE_NUM frames are in flight.
- cI_PICK: combinational search starting at rr_ptr for the first engine e with iengine_ibuf_full[e]=0 and e not already in flight (busy mask).
  - Found: register sel=e, set the busy bit, push e into the FIFO, set rr_ptr=e+1 (wrapping mod pENGINE_NUM), go to cI_XFER.
  - Not found: stay in cI_PICK.
- cI_XFER: ordy=1 and oengine_wsel=onehot(sel), both registered and taking effect the cycle after entry.
  - ordy is 1 only in cI_XFER.
  - ival&ieop -> cI_IDLE; ordy drops in the following cycle.
  - An isop seen mid-frame is ignored; the frame boundary is defined by ieop only.
- Dispatch latency: first word can be accepted 2 cycles after cI_IDLE with a free engine.

Output FSM:
- States: cO_IDLE, cO_WAIT, cO_READ, cO_REL.
- cO_IDLE -> cO_WAIT when the FIFO is not empty; head = FIFO top.
- cO_WAIT -> cO_READ when iengine_obuf_full[head]=1. ord_val=1 and ordsel=onehot(head) are registered.
- cO_READ: hold until iread_done=1, then -> cO_REL.
- cO_REL (1 cycle):
  - oengine_orelease[head] pulses; ord_val=0.
  - Pop the FIFO and clear the busy bit.
  - Go to cO_WAIT if the FIFO is non-empty after the pop, else cO_IDLE.
- Order guarantee: frames leave in dispatch order even if a later engine finishes first. Such an engine stays full until its turn.

Order FIFO:
- Depth pENGINE_NUM, width pENG_W; pointers wrap mod pENGINE_NUM; a count register is used for full/empty.
- Push (cI_PICK) and pop (cO_REL) in the same cycle: count unchanged, both pointers advance.
- A busy bit set by a push and a busy bit cleared by a pop in the same cycle never collide. The popped index is in flight and so cannot be picked.
- oinflight = FIFO count, registered.

Other rules:
- iread_done outside cO_READ is ignored.
- The busy mask makes a just-released engine pickable the cycle after cO_REL.
- Reset mid-frame aborts everything with no recovery handshake; engines must be reset alongside the scheduler.

Decomposition:
- Shared package ldpc_dec_sched_pkg holds:
  - typedef eng_idx_t = logic[pENG_W-1:0];
  - function onehot(eng_idx_t);
  - state enums for both FSMs;
  - constant cMAX_ENGINE=8.
- One natural sub-module: ldpc_dec_sched_fifo, the order FIFO (push, pop, count, full, empty, top).
- Round-robin search is a function in the main module.

Test Plan:
- Basic dispatch: pENGINE_NUM=4, all engines free, 4 frames of 16 words each -> oengine_wsel = 0001, 0010, 0100, 1000 in turn; oinflight reaches 4; ordy stays 0 for a fifth frame until a release.
- Skip busy engine: iengine_ibuf_full=0010 with rr_ptr=1 -> engine 2 chosen (wsel=0100); rr_ptr becomes 3.
- Out-of-order completion: dispatch to engines 0 then 1; obuf_full[1] rises before obuf_full[0] -> ordsel=0001 first; after iread_done, orelease=0001, then ordsel=0010.
- Simultaneous push/pop: FIFO count 2; cI_PICK and cO_REL in the same cycle -> count stays 2; dispatched order is preserved on output.
- iclkena low for 5 cycles mid-cI_XFER -> no state change, wsel held, no words lost; transfer resumes afterwards.
- Asynchronous reset asserted mid-cO_READ -> ord_val, ordsel and ordy go to 0 immediately without a clock edge; oinflight=0 after release.
